rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 14 +
 rtl/rr_arbiter8_pick.sv | 23 ++
 rtl/rr_arbiter8.sv | 88 ++++++++
 tb/tb_rr_arbiter8.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
// Holds the requester count, the index width and the arbiter FSM states.
package rr_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin winner search.
// The search starts one past the last granted index and wraps modulo NUM_REQ.
module rr_pick
    import rr_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
    always_comb begin
        winner  = ptr;
        any_req = |req;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[ptr + ID_W'(i)]) begin
                winner = ptr + ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time.
// A grant is released by done, a dropped request, or forcibly after HOLD_MAX cycles.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int              CNT_W     = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t            state;
    logic [ID_W-1:0]   gnt_id_q;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  hold_cnt;
    logic              timeout_q;

    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic              rel_done;
    logic              rel_drop;
    logic              rel_limit;
    logic              grant_exit;

    rr_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign rel_done   = done;
    assign rel_drop   = ~req[gnt_id_q];
    assign rel_limit  = (hold_cnt == HOLD_LAST);
    assign grant_exit = rel_done | rel_drop | rel_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt_id_q  <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= ST_GRANT;
                        gnt_id_q <= winner;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (grant_exit) begin
                        state     <= ST_GAP;
                        ptr       <= gnt_id_q;
                        // Only a pure hold-limit release is reported as a timeout.
                        timeout_q <= rel_limit & ~rel_done & ~rel_drop;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = (state == ST_GRANT);
    assign gnt_id    = gnt_id_q;
    assign gnt       = gnt_valid ? (NUM_REQ'(1) << gnt_id_q) : '0;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios then random traffic,
// compared each cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int HOLD_MAX = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Behavioural model: current owner (-1 = none), cycles it has been visible,
    // last granted index, pending one-cycle gap, expected timeout pulse.
    int m_owner;
    int m_held;
    int m_last;
    bit m_gap;
    bit m_to;

    rr_arbiter8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int rr_first(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (d || !r[m_owner] || m_held == HOLD_MAX) begin
                m_to    = !d && r[m_owner] && (m_held == HOLD_MAX);
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (r != 8'h00) begin
            m_owner = rr_first(r, m_last);
            m_held  = 1;
        end
    endtask

    task automatic check_model();
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) check("gnt_id", 32'(gnt_id), 32'(m_owner));
    endtask

    // Called at a negedge: drive, take one rising edge, then check at the next negedge.
    task automatic cycle(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int         run;
        int         to_cnt;
        bit         prev_v;
        int         seen[$];
        logic [7:0] r_cur;
        logic       d_cur;

        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester 0, released by done.
        cycle(8'h01, 1'b0);
        check("s030_gnt", 32'(gnt), 32'h01);
        check("s030_id", 32'(gnt_id), 32'h0);
        cycle(8'h01, 1'b1);
        check("s030_rel", 32'(gnt), 32'h00);
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);

        // All requesting, done on the third grant cycle: full rotation.
        do_reset();
        prev_v = 1'b0;
        for (int i = 0; i < 46; i++) begin
            cycle(8'hFF, (m_owner >= 0) && (m_held == 3));
            if (gnt_valid && !prev_v) seen.push_back(int'(gnt_id));
            prev_v = gnt_valid;
        end
        check("s031_count", 32'(seen.size() >= 9), 32'h1);
        if (seen.size() >= 9) begin
            for (int i = 0; i < 9; i++) check("s031_seq", 32'(seen[i]), 32'(i % 8));
        end

        // Lone requester 4 held past the limit: 16 grant cycles then timeout.
        do_reset();
        run = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(8'h10, 1'b0);
            if (gnt === 8'h10) run++;
        end
        check("s032_run", 32'(run), 32'd16);
        cycle(8'h10, 1'b0);
        check("s032_to", 32'(timeout), 32'h1);
        check("s032_gap", 32'(gnt), 32'h00);
        cycle(8'h10, 1'b0);
        check("s032_to_clr", 32'(timeout), 32'h0);
        cycle(8'h10, 1'b0);
        check("s032_regnt", 32'(gnt), 32'h10);

        // done on the same edge as the limit: normal release.
        for (int i = 0; i < 15; i++) cycle(8'h10, 1'b0);
        cycle(8'h10, 1'b1);
        check("s033_to", 32'(timeout), 32'h0);
        check("s033_gnt", 32'(gnt), 32'h00);
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);

        // Requester 2 drops its request; next grant goes to 5.
        do_reset();
        cycle(8'h24, 1'b0);
        check("s034_id2", 32'(gnt_id), 32'd2);
        cycle(8'h24, 1'b0);
        cycle(8'h20, 1'b0);
        check("s034_rel", 32'(gnt), 32'h00);
        check("s034_to", 32'(timeout), 32'h0);
        cycle(8'h20, 1'b0);
        cycle(8'h20, 1'b0);
        check("s034_id5", 32'(gnt), 32'h20);

        // Asynchronous reset in the middle of a grant to 6.
        do_reset();
        cycle(8'h40, 1'b0);
        cycle(8'h40, 1'b0);
        check("s035_pre", 32'(gnt), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("s035_async_gnt", 32'(gnt), 32'h00);
        check("s035_async_v", 32'(gnt_valid), 32'h0);
        check("s035_async_to", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(8'hC1, 1'b0);
        check("s035_id0", 32'(gnt), 32'h01);

        // Random traffic: slowly changing requests, occasional done strobes.
        r_cur  = 8'($urandom);
        to_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 15))
                0:       r_cur = 8'h00;
                1:       r_cur = 8'($urandom);
                2:       r_cur = 8'($urandom) & 8'($urandom);
                3:       r_cur = 8'd1 << $urandom_range(0, 7);
                default: r_cur = r_cur;
            endcase
            d_cur = ($urandom_range(0, 9) == 0);
            cycle(r_cur, d_cur);
            if (timeout) to_cnt++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
